// File: rtl/clk_monitor.sv
// clk_monitor: checks three divided clocks (/8, /16, /32 of clk_32f) sampled
// as data. Each channel measures period and high time, locks after LOCK_CNT
// consecutive good periods, and pulses an error on a bad period or a timeout.
// Ports:
//   clk_32f                  reference clock, all state updates on its rising edge
//   reset                    asynchronous active-high reset
//   clk_4f, clk_2f, clk_f    divided clocks under test (expected periods 8/16/32)
//   lock_4f, lock_2f, lock_f per-channel lock (registered)
//   all_locked               AND of the three locks (registered)
//   err_4f, err_2f, err_f    one-cycle error pulses (registered)
//   err_count                saturating total of error pulses
module clk_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             clk_4f,
  input  logic             clk_2f,
  input  logic             clk_f,
  output logic             lock_4f,
  output logic             lock_2f,
  output logic             lock_f,
  output logic             all_locked,
  output logic             err_4f,
  output logic             err_2f,
  output logic             err_f,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 6;
  localparam int unsigned GW  = 4;
  // Two spare bits so count + 3 can never wrap, even for ERR_W = 1.
  localparam int unsigned SW  = ERR_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [NCH-1:0] clk_in;
  logic [NCH-1:0] err_nxt;
  logic [NCH-1:0] lock_nxt;

  assign clk_in = {clk_f, clk_2f, clk_4f};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam logic [CW-1:0] PER  = CW'(8 << g);
    localparam logic [CW-1:0] HIGH = CW'(4 << g);

    logic          s_q, s_d;
    logic          rise, fall;
    logic [CW-1:0] per_cnt, hi_cnt, hi_lat;
    logic [GW-1:0] good_cnt, good_cnt_nxt;
    state_t        state, state_nxt;
    logic          good, timeout;
    logic          err_c, lock_c;

    assign rise    = s_q & ~s_d;
    assign fall    = ~s_q & s_d;
    assign good    = (per_cnt == PER) && (hi_lat == HIGH);
    assign timeout = !rise && (per_cnt > PER);

    // Synchronizer, period/high counters and high time captured at the fall.
    always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
        s_q     <= 1'b0;
        s_d     <= 1'b0;
        per_cnt <= '0;
        hi_cnt  <= '0;
        hi_lat  <= '0;
      end else begin
        s_q <= clk_in[g];
        s_d <= s_q;
        if (rise)
          per_cnt <= CW'(1);
        else if (per_cnt != '1)
          per_cnt <= per_cnt + CW'(1);
        if (rise)
          hi_cnt <= CW'(1);
        else if (s_q && (hi_cnt != '1))
          hi_cnt <= hi_cnt + CW'(1);
        if (fall)
          hi_lat <= hi_cnt;
      end
    end

    // State register.
    always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        good_cnt <= '0;
      end else begin
        state    <= state_nxt;
        good_cnt <= good_cnt_nxt;
      end
    end

    // Next-state logic.
    always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt    = ACQ;
            good_cnt_nxt = '0;
          end
        end
        ACQ: begin
          if (timeout) begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
          end else if (rise) begin
            if (good) begin
              good_cnt_nxt = good_cnt + GW'(1);
              if ((good_cnt + GW'(1)) == GW'(LOCK_CNT))
                state_nxt = LOCKED;
            end else begin
              good_cnt_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
          end else if (rise && !good) begin
            state_nxt    = ACQ;
            good_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = IDLE;
          good_cnt_nxt = '0;
        end
      endcase
    end

    // Output decode; registered at the top level on the same edge as the state.
    always_comb begin
      err_c  = 1'b0;
      lock_c = (state_nxt == LOCKED);
      if (state != IDLE)
        err_c = timeout || (rise && !good);
    end

    assign err_nxt[g]  = err_c;
    assign lock_nxt[g] = lock_c;
  end

  logic [SW-1:0] err_sum;

  assign err_sum = SW'(err_count) + SW'(err_nxt[0]) + SW'(err_nxt[1]) + SW'(err_nxt[2]);

  // Registered outputs and saturating error total.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      lock_4f    <= 1'b0;
      lock_2f    <= 1'b0;
      lock_f     <= 1'b0;
      all_locked <= 1'b0;
      err_4f     <= 1'b0;
      err_2f     <= 1'b0;
      err_f      <= 1'b0;
      err_count  <= '0;
    end else begin
      lock_4f    <= lock_nxt[0];
      lock_2f    <= lock_nxt[1];
      lock_f     <= lock_nxt[2];
      all_locked <= &lock_nxt;
      err_4f     <= err_nxt[0];
      err_2f     <= err_nxt[1];
      err_f      <= err_nxt[2];
      if (|err_sum[SW-1:ERR_W])
        err_count <= '1;
      else
        err_count <= err_sum[ERR_W-1:0];
    end
  end

endmodule
